// File: rtl/sim_watchdog_pkg.sv
// Shared types and message text for the simulation idle watchdog.
// Imported by the watchdog top and its testbench.
package sim_watchdog_pkg;

   typedef enum logic [1:0] {
      WAIT      = 2'd0,
      RUN       = 2'd1,
      STOP_OK   = 2'd2,
      STOP_FAIL = 2'd3
   } wd_state_t;

   localparam string MSG_OK   = "STOPPING SIMULATION";
   localparam string MSG_FAIL = "WATCHDOG TIMEOUT";

endpackage

// File: rtl/sim_popcount.sv
// Combinational population count of an N-bit vector.
// W must be at least $clog2(N+1).
module sim_popcount #(
   parameter int N = 1,
   parameter int W = 1
) (
   input  logic [N-1:0] bits,
   output logic [W-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + W'(bits[i]);
      end
   end

endmodule

// File: rtl/sim_idle_watchdog.sv
// Activity monitor: stops the simulation once valid/ready traffic
// has been quiet long enough, or flags a failure if it never starts.
module sim_idle_watchdog
   import sim_watchdog_pkg::*;
#(
   parameter int NCH            = 1,
   parameter int IDLE_CYCLES    = 1000,
   parameter int START_TIMEOUT  = 100000,
   parameter int EXPECTED_XFERS = 0,
   parameter int CW             = 32,
   parameter int FINISH         = 1
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          en,
   input  logic [NCH-1:0] valid,
   input  logic [NCH-1:0] ready,
   output logic          done,
   output logic          timeout,
   output logic [1:0]    state,
   output logic [CW-1:0] xfer_count,
   output logic [CW-1:0] idle_count
);

   localparam int PW = $clog2(NCH + 1);

   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_CYCLES);
   localparam logic [CW-1:0] ST_LIM   = CW'(START_TIMEOUT);
   localparam logic [CW-1:0] EXP_LIM  = CW'(EXPECTED_XFERS);

   wd_state_t      st;
   logic [CW-1:0]  start_cnt;
   logic [NCH-1:0] hs;
   logic [PW-1:0]  pcnt;
   logic           xfer;
   logic [CW:0]    x_sum;
   logic [CW-1:0]  x_next;
   logic [CW-1:0]  idle_next;
   logic [CW-1:0]  start_next;
   logic           x_ok;

   assign hs   = valid & ready;
   assign xfer = |hs;

   sim_popcount #(
      .N(NCH),
      .W(PW)
   ) u_pop (
      .bits (hs),
      .count(pcnt)
   );

   // Transfer total saturates instead of wrapping.
   always_comb begin
      x_sum  = {1'b0, xfer_count} + {1'b0, CW'(pcnt)};
      x_next = x_sum[CW] ? '1 : x_sum[CW-1:0];

      idle_next = idle_count;
      if (xfer) begin
         idle_next = '0;
      end else if (en && idle_count != '1) begin
         idle_next = idle_count + ONE;
      end

      start_next = start_cnt;
      if (en && start_cnt != '1) begin
         start_next = start_cnt + ONE;
      end

      x_ok = (EXPECTED_XFERS == 0) || (x_next >= EXP_LIM);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         st         <= WAIT;
         done       <= 1'b0;
         timeout    <= 1'b0;
         xfer_count <= '0;
         idle_count <= '0;
         start_cnt  <= '0;
      end else begin
         unique case (st)
            WAIT: begin
               xfer_count <= x_next;
               if (xfer) begin
                  st         <= RUN;
                  idle_count <= '0;
               end else begin
                  start_cnt <= start_next;
                  if (START_TIMEOUT != 0 && start_next == ST_LIM) begin
                     st      <= STOP_FAIL;
                     done    <= 1'b1;
                     timeout <= 1'b1;
                  end
               end
            end
            RUN: begin
               xfer_count <= x_next;
               idle_count <= idle_next;
               if (idle_next == IDLE_LIM) begin
                  st      <= x_ok ? STOP_OK : STOP_FAIL;
                  done    <= 1'b1;
                  timeout <= !x_ok;
               end
            end
            STOP_OK, STOP_FAIL: begin
            end
         endcase
      end
   end

   assign state = st;

   if (FINISH != 0) begin : g_finish
      // done is registered, so this fires one clock after the stop.
      always_ff @(posedge clk) begin
         if (nreset && done) begin
            if (timeout) begin
               $display("%s xfer_count=%0d", MSG_FAIL, xfer_count);
            end else begin
               $display("%s xfer_count=%0d", MSG_OK, xfer_count);
            end
            $finish;
         end
      end
   end

endmodule

// File: tb/tb_sim_idle_watchdog.sv
// Testbench for sim_idle_watchdog: two configurations driven in
// parallel, directed tables/sequences plus a random phase vs a model.
module tb_sim_idle_watchdog;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       en = 1'b0;
   logic [3:0] valid = '0;
   logic [3:0] ready = '0;

   logic        u0_done, u0_timeout;
   logic [1:0]  u0_state;
   logic [7:0]  u0_xfer, u0_idle;
   logic        u1_done, u1_timeout;
   logic [1:0]  u1_state;
   logic [31:0] u1_xfer, u1_idle;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sim_idle_watchdog #(
      .NCH(4), .IDLE_CYCLES(4), .START_TIMEOUT(10),
      .EXPECTED_XFERS(0), .CW(8), .FINISH(0)
   ) u0 (
      .clk(clk), .nreset(nreset), .en(en),
      .valid(valid), .ready(ready),
      .done(u0_done), .timeout(u0_timeout), .state(u0_state),
      .xfer_count(u0_xfer), .idle_count(u0_idle)
   );

   sim_idle_watchdog #(
      .NCH(4), .IDLE_CYCLES(2), .START_TIMEOUT(0),
      .EXPECTED_XFERS(10), .CW(32), .FINISH(0)
   ) u1 (
      .clk(clk), .nreset(nreset), .en(en),
      .valid(valid), .ready(ready),
      .done(u1_done), .timeout(u1_timeout), .state(u1_state),
      .xfer_count(u1_xfer), .idle_count(u1_idle)
   );

   // Reference model: one entry per DUT, plain integer arithmetic.
   longint p_idle[2] = '{4, 2};
   longint p_st[2]   = '{10, 0};
   longint p_exp[2]  = '{0, 10};
   longint p_max[2]  = '{255, 64'hFFFF_FFFF};
   longint m_st[2], m_x[2], m_idle[2], m_start[2];

   task automatic cmp(input string name, input longint act,
                      input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_st[d] = 0; m_x[d] = 0; m_idle[d] = 0; m_start[d] = 0;
      end
   endtask

   task automatic model_step();
      longint n;
      n = longint'($countones(valid & ready));
      for (int d = 0; d < 2; d++) begin
         if (m_st[d] < 2) begin
            m_x[d] = (m_x[d] + n > p_max[d]) ? p_max[d] : m_x[d] + n;
            if (m_st[d] == 0) begin
               if (n > 0) begin
                  m_st[d] = 1;
                  m_idle[d] = 0;
               end else begin
                  if (en) m_start[d]++;
                  if (p_st[d] != 0 && m_start[d] == p_st[d]) m_st[d] = 3;
               end
            end else begin
               if (n > 0) m_idle[d] = 0;
               else if (en && m_idle[d] < p_max[d]) m_idle[d]++;
               if (m_idle[d] == p_idle[d])
                  m_st[d] = (p_exp[d] == 0 || m_x[d] >= p_exp[d]) ? 2 : 3;
            end
         end
      end
   endtask

   task automatic check_model();
      cmp("u0.state", longint'(u0_state), m_st[0]);
      cmp("u0.done", longint'(u0_done), longint'(m_st[0] >= 2));
      cmp("u0.timeout", longint'(u0_timeout), longint'(m_st[0] == 3));
      cmp("u0.xfer", longint'(u0_xfer), m_x[0]);
      cmp("u0.idle", longint'(u0_idle), m_idle[0]);
      cmp("u1.state", longint'(u1_state), m_st[1]);
      cmp("u1.done", longint'(u1_done), longint'(m_st[1] >= 2));
      cmp("u1.timeout", longint'(u1_timeout), longint'(m_st[1] == 3));
      cmp("u1.xfer", longint'(u1_xfer), m_x[1]);
      cmp("u1.idle", longint'(u1_idle), m_idle[1]);
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic step(input logic e, input logic [3:0] v,
                       input logic [3:0] r);
      en = e; valid = v; ready = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic pulse_reset();
      en = 1'b0; valid = '0; ready = '0;
      nreset = 1'b0;
      model_reset();
      #1;
      cmp("rst.u0.done", longint'(u0_done), 0);
      cmp("rst.u0.state", longint'(u0_state), 0);
      check_model();
      #1;
      nreset = 1'b1;
   endtask

   typedef struct {
      logic       e;
      logic [3:0] v;
      logic [3:0] r;
      int         st;
      int         x;
      int         idle;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int dens;
      logic [3:0] rv, rr;
      tbl[0] = '{1'b1, 4'h1, 4'h1, 1, 1, 0};
      tbl[1] = '{1'b1, 4'h1, 4'h1, 1, 2, 0};
      tbl[2] = '{1'b1, 4'h1, 4'h1, 1, 3, 0};
      tbl[3] = '{1'b1, 4'h1, 4'h0, 1, 3, 1};
      tbl[4] = '{1'b1, 4'h0, 4'h1, 1, 3, 2};
      tbl[5] = '{1'b1, 4'h0, 4'h0, 1, 3, 3};
      tbl[6] = '{1'b1, 4'h0, 4'h0, 2, 3, 4};

      model_reset();
      @(negedge clk);
      check_model();
      pulse_reset();

      // Three single-channel transfers then idle: stop after edge 7.
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].e, tbl[i].v, tbl[i].r);
         cmp($sformatf("t1.state[%0d]", i), longint'(u0_state), tbl[i].st);
         cmp($sformatf("t1.xfer[%0d]", i), longint'(u0_xfer), tbl[i].x);
         cmp($sformatf("t1.idle[%0d]", i), longint'(u0_idle), tbl[i].idle);
      end
      cmp("t1.timeout", longint'(u0_timeout), 0);
      cmp("t1.done", longint'(u0_done), 1);

      // Late transfer restarts the idle window.
      pulse_reset();
      step(1'b1, 4'h2, 4'h2);
      for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0);
      cmp("t2.idle3", longint'(u0_idle), 3);
      step(1'b1, 4'h2, 4'h2);
      cmp("t2.idle0", longint'(u0_idle), 0);
      for (int i = 0; i < 3; i++) step(1'b1, 4'h0, 4'h0);
      cmp("t2.notdone", longint'(u0_done), 0);
      step(1'b1, 4'h0, 4'h0);
      cmp("t2.state", longint'(u0_state), 2);

      // Start timeout at edge 10.
      pulse_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 4'h0, 4'h0);
      cmp("t3.wait9", longint'(u0_state), 0);
      step(1'b1, 4'h0, 4'h0);
      cmp("t3.state", longint'(u0_state), 3);
      cmp("t3.timeout", longint'(u0_timeout), 1);
      cmp("t3.u1wait", longint'(u1_state), 0);
      step(1'b1, 4'hF, 4'hF);
      cmp("t3.frozen", longint'(u0_xfer), 0);

      // Transfer on the timeout edge wins.
      pulse_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 4'h0, 4'h0);
      step(1'b1, 4'h4, 4'h4);
      cmp("t3b.state", longint'(u0_state), 1);
      cmp("t3b.timeout", longint'(u0_timeout), 0);

      // Expected-transfer check on u1 (IDLE 2, need 10).
      pulse_reset();
      step(1'b1, 4'hF, 4'hF);
      step(1'b1, 4'h0, 4'h0);
      step(1'b1, 4'h0, 4'h0);
      cmp("t4.x4", longint'(u1_xfer), 4);
      cmp("t4.fail", longint'(u1_state), 3);
      pulse_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'hF);
      step(1'b1, 4'h0, 4'h0);
      step(1'b1, 4'h0, 4'h0);
      cmp("t4.x12", longint'(u1_xfer), 12);
      cmp("t4.ok", longint'(u1_state), 2);

      // en low for 5 cycles holds idle; done moves from edge 5 to 10.
      pulse_reset();
      step(1'b1, 4'h1, 4'h1);
      step(1'b1, 4'h0, 4'h0);
      step(1'b1, 4'h0, 4'h0);
      for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'h0);
      cmp("t5.hold", longint'(u0_idle), 2);
      step(1'b1, 4'h0, 4'h0);
      cmp("t5.notdone", longint'(u0_done), 0);
      step(1'b1, 4'h0, 4'h0);
      cmp("t5.done", longint'(u0_done), 1);

      // Transfers with en low still count, even in WAIT.
      pulse_reset();
      step(1'b0, 4'h3, 4'h7);
      cmp("t5b.x", longint'(u0_xfer), 2);
      cmp("t5b.run", longint'(u0_state), 1);

      // Reset mid-RUN and in STOP_OK, then resume.
      pulse_reset();
      step(1'b1, 4'h1, 4'h1);
      step(1'b1, 4'h0, 4'h0);
      pulse_reset();
      step(1'b1, 4'h1, 4'h1);
      for (int i = 0; i < 4; i++) step(1'b1, 4'h0, 4'h0);
      cmp("t6.stop", longint'(u0_state), 2);
      pulse_reset();
      step(1'b1, 4'h8, 4'h8);
      cmp("t6.resume", longint'(u0_xfer), 1);

      // Saturation of the 8-bit counter.
      pulse_reset();
      for (int i = 0; i < 70; i++) step(1'b1, 4'hF, 4'hF);
      cmp("t7.sat", longint'(u0_xfer), 255);
      cmp("t7.u1", longint'(u1_xfer), 280);

      // Random segments against the model.
      for (int s = 0; s < 25; s++) begin
         pulse_reset();
         dens = int'($urandom_range(0, 4));
         for (int c = 0; c < 80; c++) begin
            rv = 4'($urandom);
            rr = 4'($urandom);
            if ($urandom_range(0, 15) >= dens * 3) rv = '0;
            step($urandom_range(0, 9) != 0, rv, rr);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
